alu_req_driver: RTL and testbench

- Valid/ready front end that owns and drives the combinational ALU's operand/opcode inputs (alu_op, in_a, in_b) and collects result/zero into a response queue.
- Sits between a requester (decode/test sequencer) and the ALU, on the driving side of the signals the ALU monitor interface observes.
- Registered operands give a stable ALU launch point.
- Response side carries backpressure and a sequence tag.

---
 rtl/alu_req_driver.sv | 90 +++++++++
 tb/tb_alu_req_driver.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_driver.sv
// alu_req_driver: registered ALU operand launcher with a tagged, backpressured response FIFO
module alu_req_driver #(
  parameter int DEPTH = 2,
  parameter int SEQ_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  output logic [3:0]       alu_op,
  output logic [31:0]      alu_in_a,
  output logic [31:0]      alu_in_b,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_zero,
  output logic [SEQ_W-1:0] rsp_seq
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = 33 + SEQ_W;
  logic             stage_valid;
  logic [SEQ_W-1:0] stage_seq;
  logic [SEQ_W-1:0] seq_cnt;
  logic [CW-1:0]    count;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [EW-1:0]    mem [DEPTH];
  logic [EW-1:0]    last_pop;
  logic             accept;
  logic             push;
  logic             pop;
  assign accept    = req_valid && req_ready && !flush;
  assign push      = stage_valid && !flush;
  assign pop       = rsp_valid && rsp_ready && !flush;
  assign req_ready = ({1'b0, count} + (CW+1)'(stage_valid)) < (CW+1)'(DEPTH);
  assign rsp_valid = count != '0;
  assign {rsp_result, rsp_zero, rsp_seq} = rsp_valid ? mem[rd_ptr] : last_pop;
  // Launch stage: latch an accepted request onto the ALU inputs and tag it
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stage_valid <= 1'b0;
      stage_seq   <= '0;
      seq_cnt     <= '0;
      alu_op      <= '0;
      alu_in_a    <= '0;
      alu_in_b    <= '0;
    end else if (flush) begin
      stage_valid <= 1'b0;
      seq_cnt     <= '0;
    end else begin
      stage_valid <= accept;
      if (accept) begin
        alu_op    <= req_op;
        alu_in_a  <= req_a;
        alu_in_b  <= req_b;
        stage_seq <= seq_cnt;
        seq_cnt   <= seq_cnt + 1'b1;
      end
    end
  // Response queue bookkeeping; last_pop keeps the head outputs steady while empty
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      last_pop <= '0;
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        last_pop <= mem[rd_ptr];
      end
      count <= count + CW'(push) - CW'(pop);
    end
  // Capture the ALU output one cycle after launch
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {alu_result, alu_zero, stage_seq};
  no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && count == CW'(DEPTH)));
endmodule

// File: tb/tb_alu_req_driver.sv
// tb_alu_req_driver: directed table, corner sequences and randomized scoreboard for alu_req_driver
module tb_alu_req_driver;
  localparam int DEPTH = 2;
  localparam int SEQ_W = 4;
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3, OP_XOR = 4'd4,
                         OP_SLL = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7, OP_SLT = 4'd8, OP_SLTU = 4'd9;
  logic clk = 1'b0, rst = 1'b0, flush = 1'b0, req_valid = 1'b0, rsp_ready = 1'b0;
  logic req_ready, alu_zero, rsp_valid, rsp_zero;
  logic [3:0] req_op = '0, alu_op;
  logic [31:0] req_a = '0, req_b = '0, alu_in_a, alu_in_b, alu_result, rsp_result;
  logic [SEQ_W-1:0] rsp_seq;
  int tests = 0, fails = 0, cyc = 0;
  typedef struct { logic [31:0] res; logic zero; logic [SEQ_W-1:0] seq; int cyc; } exp_t;
  typedef struct { logic [3:0] op; logic [31:0] a; logic [31:0] b; logic [31:0] res; logic zero; } vec_t;
  exp_t q[$];
  vec_t vec[10];
  logic [SEQ_W-1:0] m_seq;
  logic [3:0] l_op;
  logic [31:0] l_a, l_b;
  bit last_acc, last_pop;

  alu_req_driver #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .alu_op(alu_op), .alu_in_a(alu_in_a),
    .alu_in_b(alu_in_b), .alu_result(alu_result), .alu_zero(alu_zero), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_seq(rsp_seq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLL:  return a << b[4:0];
      OP_SRL:  return a >> b[4:0];
      OP_SRA:  return 32'($signed(a) >>> b[4:0]);
      OP_SLT:  return {31'd0, $signed(a) < $signed(b)};
      OP_SLTU: return {31'd0, a < b};
      default: return 32'd0;
    endcase
  endfunction

  assign alu_result = alu_f(alu_op, alu_in_a, alu_in_b);
  assign alu_zero   = alu_result == 32'd0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic clear_model();
    q.delete();
    m_seq = '0;
    l_op = '0;
    l_a = '0;
    l_b = '0;
    last_acc = 1'b0;
    last_pop = 1'b0;
  endtask

  task automatic tick();
    bit av;
    av = 1'b0;
    if (q.size() > 0) av = q[0].cyc < cyc;
    chk("req_ready", req_ready, q.size() < DEPTH);
    chk("rsp_valid", rsp_valid, av);
    if (av && rsp_valid) begin
      chk("rsp_result", rsp_result, q[0].res);
      chk("rsp_zero", rsp_zero, q[0].zero);
      chk("rsp_seq", rsp_seq, q[0].seq);
    end
    chk("alu_op", alu_op, l_op);
    chk("alu_in_a", alu_in_a, l_a);
    chk("alu_in_b", alu_in_b, l_b);
    last_acc = req_valid && req_ready && !flush;
    last_pop = rsp_valid && rsp_ready && !flush;
    @(posedge clk);
    #1;
    cyc++;
    if (flush) begin
      q.delete();
      m_seq = '0;
    end else begin
      if (last_pop && q.size() > 0) void'(q.pop_front());
      if (last_acc) begin
        q.push_back('{alu_f(req_op, req_a, req_b), alu_f(req_op, req_a, req_b) == 32'd0, m_seq, cyc});
        m_seq++;
        l_op = req_op;
        l_a = req_a;
        l_b = req_b;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    flush = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc++;
    clear_model();
  endtask

  task automatic send(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    int n;
    req_valid = 1'b1;
    req_op = op;
    req_a = a;
    req_b = b;
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 20);
    chk("send accepted", last_acc, 1'b1);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    chk("rsp arrives", rsp_valid, 1'b1);
  endtask

  task automatic rand_req();
    req_op = 4'($urandom_range(0, 9));
    req_a = $urandom;
    req_b = ($urandom % 3 == 0) ? req_a : $urandom;
  endtask

  initial begin
    int n, acc_cnt, pops;
    logic [SEQ_W-1:0] seqs[20];
    logic [31:0] saved_a;
    vec[0] = '{OP_ADD, 32'd5, 32'd7, 32'd12, 1'b0};
    vec[1] = '{OP_SUB, 32'd10, 32'd3, 32'd7, 1'b0};
    vec[2] = '{OP_AND, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h0, 1'b1};
    vec[3] = '{OP_OR, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 1'b0};
    vec[4] = '{OP_XOR, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'h0, 1'b1};
    vec[5] = '{OP_SLL, 32'd1, 32'd31, 32'h80000000, 1'b0};
    vec[6] = '{OP_SRL, 32'h80000000, 32'd4, 32'h08000000, 1'b0};
    vec[7] = '{OP_SRA, 32'h80000000, 32'd4, 32'hF8000000, 1'b0};
    vec[8] = '{OP_SLT, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0};
    vec[9] = '{OP_SLTU, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1};
    clear_model();
    do_reset();
    chk("reset req_ready", req_ready, 1'b1);
    chk("reset rsp_valid", rsp_valid, 1'b0);
    chk("reset rsp_result", rsp_result, 32'd0);
    chk("reset rsp_zero", rsp_zero, 1'b0);
    chk("reset rsp_seq", rsp_seq, 32'd0);
    chk("reset alu_in_a", alu_in_a, 32'd0);
    chk("reset alu_op", alu_op, 32'd0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(vec[i].op, vec[i].a, vec[i].b);
      chk("vec alu_in_a", alu_in_a, vec[i].a);
      chk("vec alu_in_b", alu_in_b, vec[i].b);
      wait_rsp(n);
      chk("vec latency", n, 1);
      chk("vec result", rsp_result, vec[i].res);
      chk("vec zero", rsp_zero, vec[i].zero);
      chk("vec seq", rsp_seq, i);
    end
    req_valid = 1'b1; req_op = OP_SUB; req_a = 32'd3; req_b = 32'd3;
    tick();
    chk("b2b acc0", last_acc, 1'b1);
    req_b = 32'd4;
    tick();
    chk("b2b acc1", last_acc, 1'b1);
    req_valid = 1'b0;
    chk("b2b0 valid", rsp_valid, 1'b1);
    chk("b2b0 result", rsp_result, 32'd0);
    chk("b2b0 zero", rsp_zero, 1'b1);
    chk("b2b0 seq", rsp_seq, 32'd10);
    tick();
    chk("b2b1 valid", rsp_valid, 1'b1);
    chk("b2b1 result", rsp_result, 32'hFFFFFFFF);
    chk("b2b1 zero", rsp_zero, 1'b0);
    chk("b2b1 seq", rsp_seq, 32'd11);
    tick();
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    rand_req();
    acc_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (last_acc) begin
        acc_cnt++;
        rand_req();
      end
    end
    chk("stall accepts", acc_cnt, DEPTH);
    chk("stall req_ready", req_ready, 1'b0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (last_acc) rand_req();
    end
    req_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("drain empty", rsp_valid, 1'b0);
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    rand_req();
    acc_cnt = 0;
    pops = 0;
    n = 0;
    while (pops < 20 && n < 200) begin
      if (rsp_valid && rsp_ready) seqs[pops] = rsp_seq;
      tick();
      n++;
      if (last_pop) pops++;
      if (last_acc) begin
        acc_cnt++;
        rand_req();
        if (acc_cnt == 20) req_valid = 1'b0;
      end
    end
    chk("seq run pops", pops, 20);
    for (int i = 0; i < 20; i++) chk("seq wrap", seqs[i], i % 16);
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    rand_req();
    acc_cnt = 0;
    n = 0;
    while (acc_cnt < 2 && n < 20) begin
      tick();
      n++;
      if (last_acc) begin
        acc_cnt++;
        rand_req();
      end
    end
    chk("flush prefill", acc_cnt, 2);
    saved_a = alu_in_a;
    flush = 1'b1;
    req_op = OP_ADD; req_a = 32'd100; req_b = 32'd200;
    tick();
    flush = 1'b0;
    req_valid = 1'b0;
    chk("flush rsp_valid", rsp_valid, 1'b0);
    chk("flush req_ready", req_ready, 1'b1);
    chk("flush alu hold", alu_in_a, saved_a);
    rsp_ready = 1'b1;
    send(OP_ADD, 32'd1, 32'd2);
    wait_rsp(n);
    chk("post-flush seq", rsp_seq, 32'd0);
    chk("post-flush result", rsp_result, 32'd3);
    tick();
    rsp_ready = 1'b0;
    send(OP_ADD, 32'd20, 32'd22);
    send(OP_XOR, 32'd9, 32'd9);
    tick();
    tick();
    chk("pre-rst rsp_valid", rsp_valid, 1'b1);
    chk("pre-rst req_ready", req_ready, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    chk("async rst rsp_valid", rsp_valid, 1'b0);
    chk("async rst rsp_result", rsp_result, 32'd0);
    chk("async rst rsp_seq", rsp_seq, 32'd0);
    chk("async rst alu_in_a", alu_in_a, 32'd0);
    chk("async rst alu_op", alu_op, 32'd0);
    chk("async rst req_ready", req_ready, 1'b1);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    clear_model();
    rsp_ready = 1'b1;
    send(OP_SUB, 32'd50, 32'd8);
    wait_rsp(n);
    chk("post-rst seq", rsp_seq, 32'd0);
    chk("post-rst result", rsp_result, 32'd42);
    do_reset();
    for (int i = 0; i < 400; i++) begin
      flush = ($urandom % 40) == 0;
      rsp_ready = ($urandom % 3) != 0;
      if (!req_valid || last_acc) begin
        req_valid = ($urandom % 4) != 0;
        rand_req();
      end
      tick();
    end
    flush = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("final drain", rsp_valid, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
